// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline bus: decoded instruction from ID, registered EX view, stall status.
interface id_ex_stage_if;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write, id_is_ecall;
  logic        flush;

  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_is_ecall, ex_valid;
  logic        stall;
  logic [31:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_reg_write, id_mem_read, id_mem_write, id_is_ecall, flush,
    input  ex_rs1, ex_rs2, ex_rd, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_is_ecall, ex_valid,
           stall, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_reg_write, id_mem_read, id_mem_write, id_is_ecall, flush,
    output ex_rs1, ex_rs2, ex_rd, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_is_ecall, ex_valid,
           stall, stall_cycles
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use and ecall hazard stalls and a saturating stall counter.
// Define ECALL_HAZARD_EN to enable the ecall-after-x17-write hazard and its ECALL_WAIT state.
module id_ex_stage (
  input  logic          clk,
  input  logic          reset,
  id_ex_stage_if.slave  bus
);

  typedef enum logic {RUN, ECALL_WAIT} state_t;

  state_t      state;
  logic        load_use_hz;
  logic        ecall_hz;
  logic        stall_c;
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  always_comb begin
    load_use_hz = bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != '0) &
                  ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                   (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));
`ifdef ECALL_HAZARD_EN
    ecall_hz    = bus.id_is_ecall & bus.ex_valid & bus.ex_reg_write & (bus.ex_rd == 5'd17);
`else
    ecall_hz    = 1'b0;
`endif
  end

  // Gated by reset so a reset landing in ECALL_WAIT never shows a stall.
  always_comb begin
    stall_c = 1'b0;
    if (reset) begin
      case (state)
        RUN:        stall_c = (load_use_hz | ecall_hz) & ~bus.flush;
        ECALL_WAIT: stall_c = ~bus.flush;
        default:    stall_c = 1'b0;
      endcase
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_c && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  assign bus.stall        = stall_c;
  assign bus.stall_cycles = stall_cycles_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= RUN;
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      if (!bus.flush && (state == RUN) && ecall_hz && bus.ex_mem_read)
        state <= ECALL_WAIT;
      else
        state <= RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_mem_write <= 1'b0;
      bus.ex_is_ecall  <= 1'b0;
      bus.ex_rs1       <= '0;
      bus.ex_rs2       <= '0;
      bus.ex_rd        <= '0;
      bus.ex_pc        <= '0;
      bus.ex_rs1_data  <= '0;
      bus.ex_rs2_data  <= '0;
      bus.ex_imm       <= '0;
    end else if (bus.flush || stall_c) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_mem_write <= 1'b0;
      bus.ex_is_ecall  <= 1'b0;
      bus.ex_rs1       <= '0;
      bus.ex_rs2       <= '0;
      bus.ex_rd        <= '0;
      bus.ex_pc        <= '0;
      bus.ex_rs1_data  <= '0;
      bus.ex_rs2_data  <= '0;
      bus.ex_imm       <= '0;
    end else begin
      bus.ex_valid     <= 1'b1;
      bus.ex_reg_write <= bus.id_reg_write;
      bus.ex_mem_read  <= bus.id_mem_read;
      bus.ex_mem_write <= bus.id_mem_write;
      bus.ex_is_ecall  <= bus.id_is_ecall;
      bus.ex_rs1       <= bus.id_rs1;
      bus.ex_rs2       <= bus.id_rs2;
      bus.ex_rd        <= bus.id_rd;
      bus.ex_pc        <= bus.id_pc;
      bus.ex_rs1_data  <= bus.id_rs1_data;
      bus.ex_rs2_data  <= bus.id_rs2_data;
      bus.ex_imm       <= bus.id_imm;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a cycle-level instruction model.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef ECALL_HAZARD_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  typedef struct {
    bit        valid, rw, mr, mw, ec;
    bit [4:0]  rs1, rs2, rd;
    bit [31:0] pc, d1, d2, imm;
  } ex_t;

  ex_t         m;
  int unsigned m_wait;
  bit   [31:0] m_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    m      = '{default: 0};
    m_wait = 0;
    m_cnt  = '0;
  endtask

  task automatic set_instr(input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                           input bit use1, input bit use2, input bit rw, input bit mr,
                           input bit mw, input bit ec, input bit [31:0] pc, input bit fl);
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_rd        = rd;
    bus.id_use_rs1   = use1;
    bus.id_use_rs2   = use2;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
    bus.id_is_ecall  = ec;
    bus.id_pc        = pc;
    bus.id_rs1_data  = $urandom();
    bus.id_rs2_data  = $urandom();
    bus.id_imm       = $urandom();
    bus.flush        = fl;
  endtask

  // One clock: check stall before the edge, then the EX view and counter after it.
  task automatic run_cycle(input bit preload);
    bit lu, ec, st;
    int unsigned nxt_wait;
    #2;
    lu = m.valid && m.mr && (m.rd != 0) &&
         ((bus.id_use_rs1 && (bus.id_rs1 == m.rd)) || (bus.id_use_rs2 && (bus.id_rs2 == m.rd)));
    ec = EN && bus.id_is_ecall && m.valid && m.rw && (m.rd == 5'd17);
    st = (m_wait > 0) ? !bus.flush : ((lu || ec) && !bus.flush);
    check("stall", bus.stall, st);
    nxt_wait = (m_wait == 0 && ec && m.mr && !bus.flush) ? 1 : 0;
    if (preload) force dut.stall_cycles_d = 32'hFFFF_FFFD;
    @(posedge clk);
    if (bus.flush || st) m = '{default: 0};
    else begin
      m.valid = 1'b1;
      m.rw = bus.id_reg_write; m.mr = bus.id_mem_read;
      m.mw = bus.id_mem_write; m.ec = bus.id_is_ecall;
      m.rs1 = bus.id_rs1; m.rs2 = bus.id_rs2; m.rd = bus.id_rd;
      m.pc = bus.id_pc; m.d1 = bus.id_rs1_data; m.d2 = bus.id_rs2_data; m.imm = bus.id_imm;
    end
    if (preload) m_cnt = 32'hFFFF_FFFD;
    else if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    m_wait = nxt_wait;
    #1;
    if (preload) release dut.stall_cycles_d;
    check("ex_ctl", {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_is_ecall},
                    {m.valid, m.rw, m.mr, m.mw, m.ec});
    check("ex_idx", {bus.ex_rs1, bus.ex_rs2, bus.ex_rd}, {m.rs1, m.rs2, m.rd});
    check("ex_pc", bus.ex_pc, m.pc);
    check("ex_data", {bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm}, {m.d1, m.d2, m.imm});
    check("stall_cycles", bus.stall_cycles, m_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    clear_model();
    check("rst_valid", bus.ex_valid, 1'b0);
    check("rst_stall", bus.stall, 1'b0);
    check("rst_cnt", bus.stall_cycles, 32'd0);
    check("rst_pc", bus.ex_pc, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic bit [4:0] pick_reg();
    case ($urandom_range(0, 4))
      0:       return 5'd0;
      1:       return 5'd5;
      2:       return 5'd17;
      3:       return 5'd6;
      default: return 5'($urandom());
    endcase
  endfunction

  task automatic nop(input bit [31:0] pc);
    set_instr(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pc, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    nop(32'h0);
    clear_model();
    #1;
    check("init_valid", bus.ex_valid, 1'b0);
    check("init_stall", bus.stall, 1'b0);
    check("init_cnt", bus.stall_cycles, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // load-use: lw x5 then add x6,x5,x2
    set_instr(5'd1, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0, 32'h100, 0); run_cycle(0);
    set_instr(5'd5, 5'd2, 5'd6, 1, 1, 1, 0, 0, 0, 32'h104, 0); run_cycle(0);
    run_cycle(0);
    check("lu_cnt", bus.stall_cycles, 32'd1);

    // lw x17 then ecall
    set_instr(5'd1, 5'd0, 5'd17, 1, 0, 1, 1, 0, 0, 32'h200, 0); run_cycle(0);
    set_instr(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 32'h204, 0);
    run_cycle(0); run_cycle(0); run_cycle(0);

    // addi x17 then ecall
    set_instr(5'd0, 5'd0, 5'd17, 1, 0, 1, 0, 0, 0, 32'h300, 0); run_cycle(0);
    set_instr(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 32'h304, 0);
    run_cycle(0); run_cycle(0);

    // load-use coinciding with flush, then load to x0
    set_instr(5'd1, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0, 32'h400, 0); run_cycle(0);
    set_instr(5'd5, 5'd0, 5'd6, 1, 0, 1, 0, 0, 0, 32'h404, 1); run_cycle(0);
    set_instr(5'd1, 5'd0, 5'd0, 1, 0, 1, 1, 0, 0, 32'h408, 0); run_cycle(0);
    set_instr(5'd0, 5'd0, 5'd7, 1, 0, 1, 0, 0, 0, 32'h40C, 0); run_cycle(0);

    // reset while an ecall hazard wait may be in progress
    set_instr(5'd1, 5'd0, 5'd17, 1, 0, 1, 1, 0, 0, 32'h500, 0); run_cycle(0);
    set_instr(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 32'h504, 0); run_cycle(0);
    do_reset();
    nop(32'h0000_0040);
    run_cycle(0);
    check("post_rst_pc", bus.ex_pc, 32'h0000_0040);

    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset();
      set_instr(pick_reg(), pick_reg(), pick_reg(),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                $urandom(), 1'($urandom_range(0, 7) == 0));
      run_cycle(0);
    end

    // counter saturation
    nop(32'h600);
    run_cycle(1);
    for (int i = 0; i < 4; i++) begin
      set_instr(5'd1, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0, 32'h700, 0); run_cycle(0);
      set_instr(5'd5, 5'd0, 5'd6, 1, 0, 1, 0, 0, 0, 32'h704, 0); run_cycle(0);
    end
    check("sat_cnt", bus.stall_cycles, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL: id_rs1, id_rs2, id_rd  input  5 each  register indices decoded in ID.
REQ-004 SHALL: id_use_rs1, id_use_rs2  input  1 each  instruction actually reads rs1/rs2.
REQ-005 SHALL: id_pc, id_rs1_data, id_rs2_data, id_imm  input  32 each  ID payload.
REQ-006 SHALL: id_reg_write, id_mem_read, id_mem_write, id_is_ecall  input  1 each  ID control.
REQ-007 SHALL: flush  input  1  branch mispredict from EX; kill instruction in ID.
REQ-008 SHALL: ex_rs1, ex_rs2, ex_rd  output  5 each  registered indices, feed forwarding unit.
REQ-009 SHALL: ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  32 each  registered payload.
REQ-010 SHALL: ex_reg_write, ex_mem_read, ex_mem_write, ex_is_ecall, ex_valid  output  1 each  registered control.
REQ-011 SHALL: stall  output  1  combinational; holds PC and IF/ID register this cycle.
REQ-012 SHALL: stall_cycles  output  32  saturating count of cycles with stall=1.

Function
REQ-013 SHALL: load-use hazard = ex_valid & ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-014 SHALL: ecall hazard = id_is_ecall & ex_valid & ex_reg_write & ex_rd==17.
REQ-015 SHALL: FSM states RUN and ECALL_WAIT; reset state RUN.
REQ-016 SHALL: in RUN, stall = (load-use hazard | ecall hazard) & !flush.
REQ-017 SHALL: RUN -> ECALL_WAIT when ecall hazard & ex_mem_read & !flush; otherwise stay RUN.
REQ-018 SHALL: in ECALL_WAIT, stall = !flush; next state always RUN.
REQ-019 SHALL: on edge with flush=1 or stall=1, load bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_ecall = 0; indices and payload = 0.
REQ-020 SHALL: otherwise on edge, register every id_* input into its ex_* output and set ex_valid=1.
REQ-021 SHALL: flush overrides stall in same cycle; stall=0, FSM -> RUN.
REQ-022 SHALL: latency ID->EX exactly one cycle when no stall/flush.
REQ-023 SHALL: load-use stall length exactly 1 cycle; ecall-after-load-to-x17 stall length exactly 2 cycles; ecall-after-ALU-write-to-x17 exactly 1 cycle.
REQ-024 SHALL: stall_cycles increments by 1 on each edge where stall=1; holds at 32'hFFFF_FFFF (no wrap).
REQ-025 SHALL: writes to x0 never cause hazard (ex_rd==0 excluded in REQ-013; REQ-014 compares only against 17).

Reset
REQ-026 SHALL: reset=0 asynchronously clears all ex_* outputs, ex_valid, stall_cycles to 0 and FSM to RUN.
REQ-027 SHALL: stall = 0 while reset=0, including reset asserted mid ECALL_WAIT; first post-reset cycle starts in RUN.

Configuration
REQ-028 SHALL: macro ECALL_HAZARD_EN defined -> ecall hazard (REQ-014, REQ-017, ECALL_WAIT) active.
REQ-029 SHALL: ECALL_HAZARD_EN undefined -> ecall hazard forced 0, ECALL_WAIT unreachable, FSM stays RUN; load-use logic unchanged.

Verification
REQ-030 SHALL: lw x5 in EX (ex_mem_read=1, ex_rd=5), add using rs1=5 in ID -> stall=1 one cycle, bubble (ex_valid=0) next edge, add enters EX on following edge, stall_cycles=1.
REQ-031 SHALL: lw x17 in EX, ecall in ID (EN defined) -> stall=1 two consecutive cycles, FSM RUN->ECALL_WAIT->RUN, two bubbles, stall_cycles=2.
REQ-032 SHALL: addi x17 in EX, ecall in ID -> stall one cycle; same stimulus with ECALL_HAZARD_EN undefined -> stall=0, ecall registered next edge.
REQ-033 SHALL: load-use hazard and flush=1 same cycle -> stall=0, bubble loaded, stall_cycles unchanged; lw to x0 with rs1=0 consumer -> no stall.
REQ-034 SHALL: reset=0 pulsed while in ECALL_WAIT -> immediately ex_valid=0, stall=0, stall_cycles=0; after release, id_pc=32'h0000_0040 appears on ex_pc after one edge.
REQ-035 SHALL: stall_cycles preloaded near saturation via forced stalls -> reaches 32'hFFFF_FFFF and holds under further stalls.
